// File: rtl/core_ifu_fetch_ctrl_if.sv
// Interface bundling every non-clock/reset signal of the IFU fetch controller.
//   slave  : view used by core_ifu_fetch_ctrl
//   master : view used by whoever drives the controller (fetch generator, bus, consumer)
// Signals: flush, fetch_rx_* (request in), bus_req_* (request out), bus_rsp_* (response in),
//          fetch_tx_* (instruction out), outstanding (live in-flight count).
interface core_ifu_fetch_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUF_DEPTH  = 8,
    parameter int unsigned CNT_W      = $clog2(BUF_DEPTH + 1)
);
    logic                  flush;
    logic                  fetch_rx_valid;
    logic                  fetch_rx_ready;
    logic [ADDR_WIDTH-1:0] fetch_rx_addr;
    logic                  bus_req_valid;
    logic                  bus_req_ready;
    logic [ADDR_WIDTH-1:0] bus_req_addr;
    logic                  bus_rsp_valid;
    logic [DATA_WIDTH-1:0] bus_rsp_data;
    logic                  bus_rsp_err;
    logic                  fetch_tx_valid;
    logic                  fetch_tx_ready;
    logic [DATA_WIDTH-1:0] fetch_tx_inst;
    logic [ADDR_WIDTH-1:0] fetch_tx_addr;
    logic                  fetch_tx_err;
    logic [CNT_W-1:0]      outstanding;

    modport slave (
        input  flush, fetch_rx_valid, fetch_rx_addr, bus_req_ready,
               bus_rsp_valid, bus_rsp_data, bus_rsp_err, fetch_tx_ready,
        output fetch_rx_ready, bus_req_valid, bus_req_addr,
               fetch_tx_valid, fetch_tx_inst, fetch_tx_addr, fetch_tx_err, outstanding
    );

    modport master (
        output flush, fetch_rx_valid, fetch_rx_addr, bus_req_ready,
               bus_rsp_valid, bus_rsp_data, bus_rsp_err, fetch_tx_ready,
        input  fetch_rx_ready, bus_req_valid, bus_req_addr,
               fetch_tx_valid, fetch_tx_inst, fetch_tx_addr, fetch_tx_err, outstanding
    );
endinterface

// File: rtl/core_ifu_fetch_ctrl.sv
// IFU fetch controller: forwards fetch requests to an in-order ready/valid instruction bus,
// remembers request addresses, pairs each response with its address in a FWFT output buffer
// and throttles issue with credits so the buffer can never overflow. A flush discards the
// buffer and turns every in-flight request into a pending drop.
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset; all outputs forced to 0 while low
//   io   - core_ifu_fetch_ctrl_if.slave (request, bus, response, instruction, count signals)
module core_ifu_fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned BUF_DEPTH       = 8,
    parameter int unsigned CNT_W           = $clog2(BUF_DEPTH + 1)
) (
    input logic                 clk,
    input logic                 rstn,
    core_ifu_fetch_ctrl_if.slave io
);
    localparam int unsigned AqPtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned BufPtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_W:0]     MaxOutW   = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0]     BufDepthW = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [AqPtrW-1:0]  AqLast    = AqPtrW'(MAX_OUTSTANDING - 1);
    localparam logic [BufPtrW-1:0] BufLast   = BufPtrW'(BUF_DEPTH - 1);

    logic [CNT_W-1:0]   out_q, out_d, drop_q, drop_d, buf_cnt_q, buf_cnt_d;
    logic [AqPtrW-1:0]  aq_wptr_q, aq_wptr_d, aq_rptr_q, aq_rptr_d;
    logic [BufPtrW-1:0] buf_wptr_q, buf_wptr_d, buf_rptr_q, buf_rptr_d;

    logic [ADDR_WIDTH-1:0] aq_mem_q   [MAX_OUTSTANDING];
    logic [ADDR_WIDTH-1:0] buf_addr_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
    logic                  buf_err_q  [BUF_DEPTH];

    logic [CNT_W:0] out_drop_sum, out_buf_sum;
    logic credit_ok, issue, rsp_drop, rsp_live, push, pop, tx_valid;

    always_comb begin
        out_drop_sum = {1'b0, out_q} + {1'b0, drop_q};
        out_buf_sum  = {1'b0, out_q} + {1'b0, buf_cnt_q};
        // Second term reserves a buffer slot for every in-flight request.
        credit_ok    = (out_drop_sum < MaxOutW) && (out_buf_sum < BufDepthW);
        issue        = io.fetch_rx_valid && io.bus_req_ready && credit_ok && !io.flush;
        rsp_drop     = io.bus_rsp_valid && (drop_q != '0);
        rsp_live     = io.bus_rsp_valid && (drop_q == '0) && (out_q != '0);
        push         = rsp_live && !io.flush;
        tx_valid     = (buf_cnt_q != '0);
        pop          = tx_valid && io.fetch_tx_ready;
    end

    always_comb begin
        out_d      = out_q;
        drop_d     = drop_q;
        buf_cnt_d  = buf_cnt_q;
        aq_wptr_d  = aq_wptr_q;
        aq_rptr_d  = aq_rptr_q;
        buf_wptr_d = buf_wptr_q;
        buf_rptr_d = buf_rptr_q;
        if (io.flush) begin
            // Every live request becomes a drop, except one answered in this very cycle.
            drop_d     = drop_q + out_q - CNT_W'(rsp_drop) - CNT_W'(rsp_live);
            out_d      = '0;
            buf_cnt_d  = '0;
            aq_wptr_d  = '0;
            aq_rptr_d  = '0;
            buf_wptr_d = '0;
            buf_rptr_d = '0;
        end else begin
            drop_d    = drop_q - CNT_W'(rsp_drop);
            out_d     = out_q + CNT_W'(issue) - CNT_W'(rsp_live);
            buf_cnt_d = buf_cnt_q + CNT_W'(push) - CNT_W'(pop);
            if (issue) aq_wptr_d = (aq_wptr_q == AqLast) ? '0 : aq_wptr_q + 1'b1;
            if (rsp_live) aq_rptr_d = (aq_rptr_q == AqLast) ? '0 : aq_rptr_q + 1'b1;
            if (push) buf_wptr_d = (buf_wptr_q == BufLast) ? '0 : buf_wptr_q + 1'b1;
            if (pop) buf_rptr_d = (buf_rptr_q == BufLast) ? '0 : buf_rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q      <= '0;
            drop_q     <= '0;
            buf_cnt_q  <= '0;
            aq_wptr_q  <= '0;
            aq_rptr_q  <= '0;
            buf_wptr_q <= '0;
            buf_rptr_q <= '0;
        end else begin
            out_q      <= out_d;
            drop_q     <= drop_d;
            buf_cnt_q  <= buf_cnt_d;
            aq_wptr_q  <= aq_wptr_d;
            aq_rptr_q  <= aq_rptr_d;
            buf_wptr_q <= buf_wptr_d;
            buf_rptr_q <= buf_rptr_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (issue) aq_mem_q[aq_wptr_q] <= io.fetch_rx_addr;
        if (push) begin
            buf_addr_q[buf_wptr_q] <= aq_mem_q[aq_rptr_q];
            buf_data_q[buf_wptr_q] <= io.bus_rsp_data;
            buf_err_q[buf_wptr_q]  <= io.bus_rsp_err;
        end
    end

    // Outputs are gated with rstn so they read 0 for the whole reset window.
    always_comb begin
        io.bus_req_valid  = rstn && io.fetch_rx_valid && credit_ok && !io.flush;
        io.fetch_rx_ready = rstn && io.bus_req_ready && credit_ok && !io.flush;
        io.bus_req_addr   = rstn ? io.fetch_rx_addr : '0;
        io.fetch_tx_valid = rstn && tx_valid;
        io.fetch_tx_inst  = rstn ? buf_data_q[buf_rptr_q] : '0;
        io.fetch_tx_addr  = rstn ? buf_addr_q[buf_rptr_q] : '0;
        io.fetch_tx_err   = rstn && buf_err_q[buf_rptr_q];
        io.outstanding    = rstn ? out_q : '0;
    end

    buf_no_overflow_a: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && (buf_cnt_q == CNT_W'(BUF_DEPTH))));
endmodule

// File: tb/tb_core_ifu_fetch_ctrl.sv
// Directed bench for core_ifu_fetch_ctrl (default parameters: 4 outstanding, 8-entry buffer).
module tb_core_ifu_fetch_ctrl;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 4;
    localparam int unsigned BD = 8;
    localparam int unsigned CW = $clog2(BD + 1);

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    core_ifu_fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_W(CW)) io ();

    core_ifu_fetch_ctrl #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_OUTSTANDING(MO),
        .BUF_DEPTH      (BD),
        .CNT_W          (CW)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .io  (io)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic issued_last;
        int   acc;
        int   nrsp;

        rstn = 1'b0;
        io.flush = 1'b0;
        io.fetch_rx_valid = 1'b1;
        io.fetch_rx_addr = 32'h1234;
        io.bus_req_ready = 1'b1;
        io.bus_rsp_valid = 1'b0;
        io.bus_rsp_data = '0;
        io.bus_rsp_err = 1'b0;
        io.fetch_tx_ready = 1'b0;
        #3;
        // Reset: outputs are 0 even with requests presented.
        chk("rst_req_valid", io.bus_req_valid, 0);
        chk("rst_rx_ready", io.fetch_rx_ready, 0);
        chk("rst_req_addr", io.bus_req_addr, 0);
        chk("rst_tx_valid", io.fetch_tx_valid, 0);
        chk("rst_outstanding", io.outstanding, 0);
        io.fetch_rx_valid = 1'b0;
        tick();
        tick();
        rstn = 1'b1;

        // 1: single fetch
        io.fetch_rx_valid = 1'b1;
        io.fetch_rx_addr = 32'h1000;
        #1;
        chk("t1_req_valid", io.bus_req_valid, 1);
        chk("t1_rx_ready", io.fetch_rx_ready, 1);
        chk("t1_req_addr", io.bus_req_addr, 32'h1000);
        tick();
        io.fetch_rx_valid = 1'b0;
        #1;
        chk("t1_outstanding", io.outstanding, 1);
        tick();
        tick();
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data = 32'h13;
        #1;
        chk("t1_tx_valid_pre", io.fetch_tx_valid, 0);
        tick();
        io.bus_rsp_valid = 1'b0;
        #1;
        chk("t1_tx_valid", io.fetch_tx_valid, 1);
        chk("t1_tx_inst", io.fetch_tx_inst, 32'h13);
        chk("t1_tx_addr", io.fetch_tx_addr, 32'h1000);
        chk("t1_tx_err", io.fetch_tx_err, 0);
        chk("t1_outstanding0", io.outstanding, 0);
        io.fetch_tx_ready = 1'b1;
        tick();
        io.fetch_tx_ready = 1'b0;
        #1;
        chk("t1_tx_valid_after_pop", io.fetch_tx_valid, 0);

        // 2: no responses, 6 fetches, only 4 issue
        for (int i = 0; i < 6; i++) begin
            io.fetch_rx_valid = 1'b1;
            io.fetch_rx_addr = 32'h100 + 32'(4 * i);
            #1;
            chk("t2_rx_ready", io.fetch_rx_ready, (i < 4) ? 1 : 0);
            tick();
        end
        io.fetch_rx_valid = 1'b0;
        #1;
        chk("t2_outstanding", io.outstanding, 4);
        io.bus_rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            io.bus_rsp_data = 32'hB000 + 32'(i);
            tick();
        end
        io.bus_rsp_valid = 1'b0;
        io.fetch_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_tx_addr", io.fetch_tx_addr, 32'h100 + 32'(4 * i));
            chk("t2_tx_inst", io.fetch_tx_inst, 32'hB000 + 32'(i));
            tick();
        end
        io.fetch_tx_ready = 1'b0;
        #1;
        chk("t2_drained", io.fetch_tx_valid, 0);

        // 3: bus answers next cycle, consumer stalled: buffer fills to 8
        issued_last = 1'b0;
        acc = 0;
        nrsp = 0;
        for (int c = 0; c < 12; c++) begin
            io.fetch_rx_valid = (acc < 10);
            io.fetch_rx_addr = 32'h4000 + 32'(4 * acc);
            io.bus_rsp_valid = issued_last;
            io.bus_rsp_data = 32'hA000 + 32'(nrsp);
            #1;
            chk("t3_rx_ready", io.fetch_rx_ready, (c <= 7) ? 1 : 0);
            issued_last = io.bus_req_valid && io.bus_req_ready;
            if (issued_last) acc++;
            if (io.bus_rsp_valid) nrsp++;
            tick();
        end
        io.bus_rsp_valid = 1'b0;
        #1;
        chk("t3_accepted", 64'(acc), 8);
        chk("t3_rx_ready_full", io.fetch_rx_ready, 0);
        chk("t3_outstanding", io.outstanding, 0);
        chk("t3_head_addr", io.fetch_tx_addr, 32'h4000);
        chk("t3_head_inst", io.fetch_tx_inst, 32'hA000);
        io.fetch_rx_valid = 1'b0;
        io.fetch_tx_ready = 1'b1;
        tick();
        io.fetch_tx_ready = 1'b0;
        io.fetch_rx_valid = 1'b1;
        io.fetch_rx_addr = 32'h4020;
        #1;
        chk("t3_rx_ready_after_pop", io.fetch_rx_ready, 1);
        tick();
        io.fetch_rx_valid = 1'b0;
        #1;
        chk("t3_outstanding1", io.outstanding, 1);
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data = 32'hA008;
        tick();
        io.bus_rsp_valid = 1'b0;
        io.fetch_tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t3_tx_addr", io.fetch_tx_addr, 32'h4004 + 32'(4 * k));
            chk("t3_tx_inst", io.fetch_tx_inst, 32'hA001 + 32'(k));
            tick();
        end
        io.fetch_tx_ready = 1'b0;
        #1;
        chk("t3_drained", io.fetch_tx_valid, 0);

        // 4: 2 buffered + 3 in flight, flush
        io.fetch_rx_valid = 1'b1;
        io.fetch_rx_addr = 32'h5000;
        tick();
        io.fetch_rx_addr = 32'h5004;
        tick();
        io.fetch_rx_valid = 1'b0;
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data = 32'hC000;
        tick();
        io.bus_rsp_data = 32'hC001;
        tick();
        io.bus_rsp_valid = 1'b0;
        io.fetch_rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io.fetch_rx_addr = 32'h5008 + 32'(4 * i);
            tick();
        end
        io.fetch_rx_valid = 1'b0;
        #1;
        chk("t4_outstanding3", io.outstanding, 3);
        chk("t4_tx_valid_pre", io.fetch_tx_valid, 1);
        io.flush = 1'b1;
        io.fetch_rx_valid = 1'b1;
        io.fetch_rx_addr = 32'h5555;
        #1;
        chk("t4_flush_req_valid", io.bus_req_valid, 0);
        chk("t4_flush_rx_ready", io.fetch_rx_ready, 0);
        tick();
        io.flush = 1'b0;
        io.fetch_rx_addr = 32'h2000;
        #1;
        chk("t4_tx_valid_flushed", io.fetch_tx_valid, 0);
        chk("t4_outstanding0", io.outstanding, 0);
        chk("t4_rx_ready_drops3", io.fetch_rx_ready, 1);
        tick();
        io.fetch_rx_valid = 1'b0;
        #1;
        chk("t4_rx_ready_credit", io.fetch_rx_ready, 0);
        chk("t4_outstanding_new", io.outstanding, 1);
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data = 32'hDEAD;
        for (int i = 0; i < 3; i++) tick();
        io.bus_rsp_data = 32'hD000;
        #1;
        chk("t4_dropped_all", io.fetch_tx_valid, 0);
        chk("t4_rx_ready_freed", io.fetch_rx_ready, 1);
        tick();
        io.bus_rsp_valid = 1'b0;
        #1;
        chk("t4_new_valid", io.fetch_tx_valid, 1);
        chk("t4_new_addr", io.fetch_tx_addr, 32'h2000);
        chk("t4_new_inst", io.fetch_tx_inst, 32'hD000);
        chk("t4_outstanding_end", io.outstanding, 0);
        io.fetch_tx_ready = 1'b1;
        tick();
        io.fetch_tx_ready = 1'b0;

        // 5: flush coinciding with a live response, 2 in flight
        io.fetch_rx_valid = 1'b1;
        io.fetch_rx_addr = 32'h6000;
        tick();
        io.fetch_rx_addr = 32'h6004;
        tick();
        io.fetch_rx_valid = 1'b0;
        io.flush = 1'b1;
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data = 32'hE000;
        tick();
        io.flush = 1'b0;
        io.bus_rsp_data = 32'hE001;
        #1;
        chk("t5_outstanding0", io.outstanding, 0);
        chk("t5_tx_valid0", io.fetch_tx_valid, 0);
        tick();
        io.bus_rsp_valid = 1'b0;
        #1;
        chk("t5_late_dropped", io.fetch_tx_valid, 0);
        io.fetch_rx_valid = 1'b1;
        io.fetch_rx_addr = 32'h6100;
        tick();
        io.fetch_rx_valid = 1'b0;
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data = 32'hE100;
        tick();
        io.bus_rsp_valid = 1'b0;
        #1;
        chk("t5_live_valid", io.fetch_tx_valid, 1);
        chk("t5_live_addr", io.fetch_tx_addr, 32'h6100);
        chk("t5_live_inst", io.fetch_tx_inst, 32'hE100);
        io.fetch_tx_ready = 1'b1;
        tick();
        io.fetch_tx_ready = 1'b0;

        // 6: error response, then async reset mid-burst
        io.fetch_rx_valid = 1'b1;
        io.fetch_rx_addr = 32'h3000;
        tick();
        io.fetch_rx_addr = 32'h3004;
        tick();
        io.fetch_rx_valid = 1'b0;
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data = 32'hF000;
        io.bus_rsp_err = 1'b0;
        tick();
        io.bus_rsp_data = 32'hF004;
        io.bus_rsp_err = 1'b1;
        tick();
        io.bus_rsp_valid = 1'b0;
        io.bus_rsp_err = 1'b0;
        #1;
        chk("t6_first_addr", io.fetch_tx_addr, 32'h3000);
        chk("t6_first_err", io.fetch_tx_err, 0);
        io.fetch_tx_ready = 1'b1;
        tick();
        #1;
        chk("t6_err_addr", io.fetch_tx_addr, 32'h3004);
        chk("t6_err_inst", io.fetch_tx_inst, 32'hF004);
        chk("t6_err_flag", io.fetch_tx_err, 1);
        tick();
        io.fetch_tx_ready = 1'b0;
        io.fetch_rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io.fetch_rx_addr = 32'h7000 + 32'(4 * i);
            tick();
        end
        io.fetch_rx_valid = 1'b0;
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data = 32'h7A00;
        tick();
        io.bus_rsp_valid = 1'b0;
        io.fetch_rx_valid = 1'b1;
        io.fetch_rx_addr = 32'h7777;
        #1;
        chk("t6_pre_rst_tx_valid", io.fetch_tx_valid, 1);
        chk("t6_pre_rst_outstanding", io.outstanding, 2);
        rstn = 1'b0;
        #1;
        chk("t6_rst_req_valid", io.bus_req_valid, 0);
        chk("t6_rst_rx_ready", io.fetch_rx_ready, 0);
        chk("t6_rst_req_addr", io.bus_req_addr, 0);
        chk("t6_rst_tx_valid", io.fetch_tx_valid, 0);
        chk("t6_rst_tx_inst", io.fetch_tx_inst, 0);
        chk("t6_rst_tx_addr", io.fetch_tx_addr, 0);
        chk("t6_rst_tx_err", io.fetch_tx_err, 0);
        chk("t6_rst_outstanding", io.outstanding, 0);
        #1;
        rstn = 1'b1;
        io.fetch_rx_valid = 1'b0;
        tick();
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data = 32'h7B00;
        tick();
        tick();
        io.bus_rsp_valid = 1'b0;
        #1;
        chk("t6_stale_tx_valid", io.fetch_tx_valid, 0);
        chk("t6_stale_outstanding", io.outstanding, 0);
        io.fetch_rx_valid = 1'b1;
        io.fetch_rx_addr = 32'h7100;
        tick();
        io.fetch_rx_valid = 1'b0;
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data = 32'h7C00;
        tick();
        io.bus_rsp_valid = 1'b0;
        #1;
        chk("t6_post_rst_addr", io.fetch_tx_addr, 32'h7100);
        chk("t6_post_rst_inst", io.fetch_tx_inst, 32'h7C00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
